// File: rtl/toggle_synchronizer_1clk.sv
// -----------------------------------------------------------------------------
// toggle_synchronizer_1clk
//
// Pulse-transfer synchronizer, single-clock form. An accepted one-cycle
// request flips a toggle flop. The level change ripples through a G_STAGES
// flop chain and is edge-detected back into a one-cycle pulse. o_pulse_B is
// intended as the load enable of a downstream recirculation-mux capture
// register.
//
// A request that arrives while a previous one is still in flight is dropped,
// not merged. The drop is recorded in the sticky o_overrun flag.
//
// Parameters:
//   G_STAGES   synchronizer chain depth, legal range 2..8 (default 2).
//
// Ports:
//   i_clk      single clock; all state is rising-edge triggered.
//   i_rst      synchronous reset, active-high; clears every flop.
//   i_pulse_A  request pulse, sampled on every rising edge.
//   o_pulse_B  one-cycle pulse, one per accepted request, G_STAGES+1 cycles
//              after the request.
//   o_busy     high while an accepted request is in flight.
//   o_overrun  sticky: a request was dropped because o_busy was high.
//
// Optional build macro:
//   TOGGLE_SYNC_ASSERT_EN  compiles in concurrent assertions and cover
//                          points. RTL behaviour is identical with or
//                          without this macro.
// -----------------------------------------------------------------------------
module toggle_synchronizer_1clk #(
  parameter int G_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse_A,
  output logic o_pulse_B,
  output logic o_busy,
  output logic o_overrun
);

  generate
    if (G_STAGES < 2 || G_STAGES > 8) begin : g_bad_stages
      $error("toggle_synchronizer_1clk: G_STAGES must be in 2..8");
    end
  endgenerate

  logic                toggle_q, toggle_d;
  logic [G_STAGES-1:0] sync_q, sync_d;
  logic                last_q, last_d;
  logic                overrun_q, overrun_d;
  logic                busy;
  logic                accept;

  always_comb begin
    // The toggle and r_last differ exactly while a toggle edge is still
    // travelling down the chain. This covers the cycle in which the
    // output pulse fires.
    busy      = toggle_q ^ last_q;
    accept    = i_pulse_A & ~busy;
    toggle_d  = toggle_q ^ accept;
    sync_d    = {sync_q[G_STAGES-2:0], toggle_q};
    last_d    = sync_q[G_STAGES-1];
    overrun_d = overrun_q | (i_pulse_A & busy);
  end

  // Toggle, chain, edge-detect and overrun registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      toggle_q  <= 1'b0;
      sync_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      sync_q    <= sync_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_pulse_B = sync_q[G_STAGES-1] ^ last_q;
  assign o_busy    = busy;
  assign o_overrun = overrun_q;

`ifdef TOGGLE_SYNC_ASSERT_EN
  a_no_back_to_back: assert property (@(posedge i_clk) disable iff (i_rst)
    o_pulse_B |=> !o_pulse_B);

  a_accept_gives_pulse: assert property (@(posedge i_clk) disable iff (i_rst)
    accept |-> ##(G_STAGES+1) o_pulse_B);

  a_pulse_has_request: assert property (@(posedge i_clk) disable iff (i_rst)
    o_pulse_B |-> $past(accept & ~i_rst, G_STAGES+1));

  a_overrun_sticky: assert property (@(posedge i_clk) disable iff (i_rst)
    o_overrun |=> o_overrun);

  c_accept:  cover property (@(posedge i_clk) disable iff (i_rst) accept);
  c_overrun: cover property (@(posedge i_clk) disable iff (i_rst)
    i_pulse_A && busy);
`endif

endmodule

// File: tb/tb_toggle_synchronizer_1clk.sv
// -----------------------------------------------------------------------------
// Bench for toggle_synchronizer_1clk. Two instances run side by side:
// u_g2 uses G_STAGES=2 and u_g3 uses G_STAGES=3. Each instance is compared
// every cycle against a reference model. The model remembers only the cycle
// of the last accepted request and a sticky drop flag, and from those it
// derives busy, pulse and overrun with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_toggle_synchronizer_1clk;

  localparam int NONE = -100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   [2];
  logic pin   [2];
  logic pulse [2];
  logic busy  [2];
  logic ovr   [2];

  toggle_synchronizer_1clk #(.G_STAGES(2)) u_g2 (
    .i_clk(clk), .i_rst(rst[0]), .i_pulse_A(pin[0]),
    .o_pulse_B(pulse[0]), .o_busy(busy[0]), .o_overrun(ovr[0]));

  toggle_synchronizer_1clk #(.G_STAGES(3)) u_g3 (
    .i_clk(clk), .i_rst(rst[1]), .i_pulse_A(pin[1]),
    .o_pulse_B(pulse[1]), .o_busy(busy[1]), .o_overrun(ovr[1]));

  int nvec = 0;
  int nerr = 0;

  // Reference model state, one slot per instance.
  int gst     [2] = '{2, 3};
  int acc_cyc [2] = '{NONE, NONE};
  bit m_ovr   [2] = '{1'b0, 1'b0};
  int cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int i);
    int d = cyc - acc_cyc[i];
    return (acc_cyc[i] != NONE) && d >= 1 && d <= gst[i] + 1;
  endfunction

  function automatic bit m_pulse(input int i);
    return (acc_cyc[i] != NONE) && (cyc - acc_cyc[i] == gst[i] + 1);
  endfunction

  // Called #1 after a rising edge. It checks the current cycle, drives
  // that cycle's inputs, and then advances across the next edge.
  task automatic step(input bit p0, input bit r0, input bit p1, input bit r1);
    bit p[2];
    bit r[2];
    p = '{p0, p1};
    r = '{r0, r1};
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pulse_g%0d", gst[i]), int'(pulse[i]), int'(m_pulse(i)));
      chk($sformatf("busy_g%0d",  gst[i]), int'(busy[i]),  int'(m_busy(i)));
      chk($sformatf("ovr_g%0d",   gst[i]), int'(ovr[i]),   int'(m_ovr[i]));
    end
    pin[0] = p0; rst[0] = r0;
    pin[1] = p1; rst[1] = r1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r[i]) begin
        acc_cyc[i] = NONE;
        m_ovr[i]   = 1'b0;
      end else if (p[i]) begin
        if (m_busy(i)) m_ovr[i] = 1'b1;
        else           acc_cyc[i] = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  initial begin
    // The first reset edge gives every flop a defined value. Comparisons
    // start from the cycle that follows it.
    rst[0] = 1; rst[1] = 1; pin[0] = 1; pin[1] = 1;
    @(posedge clk); #1;

    // Reset held with the request high; outputs must stay low.
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    idle(3);

    // Single request.
    step(1, 0, 1, 0);
    idle(7);

    // Back-to-back requests: one output pulse, overrun set.
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    idle(7);
    step(0, 1, 0, 1);

    // Max rate on G=2 (cycles 0,4,8); level held for 10 cycles on G=3.
    for (int k = 0; k < 12; k++)
      step((k % 4 == 0) && k <= 8, 0, k < 10, 0);
    idle(4);
    step(0, 1, 0, 1);

    // Reset mid-flight: no pulse may follow.
    step(1, 0, 1, 0);
    step(0, 1, 0, 1);
    idle(8);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
